// File: rtl/if_id_queue.sv
`default_nettype none
// ============================================================================
// Module   : if_id_queue
// Purpose  : IF/ID pipeline boundary implemented as a DEPTH-entry instruction
//            queue with valid/ready handshakes on both sides. Fetch may run
//            ahead of a stalled decode; a flush empties the queue in one edge.
// Ports    : clk, rst (async, active-high), flush (sync discard)
//            if_valid/if_pc/if_inst/if_ready   - fetch side (enqueue)
//            id_valid/id_pc/id_inst/id_ready   - decode side (dequeue)
//            count                             - current occupancy
// Revision : 1.0 - initial release
// ============================================================================
module if_id_queue #(
    parameter int ADDR_WIDTH = 32,
    parameter int INST_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       if_valid,
    input  logic [ADDR_WIDTH-1:0]      if_pc,
    input  logic [INST_WIDTH-1:0]      if_inst,
    output logic                       if_ready,
    output logic                       id_valid,
    output logic [ADDR_WIDTH-1:0]      id_pc,
    output logic [INST_WIDTH-1:0]      id_inst,
    input  logic                       id_ready,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(DEPTH);
    localparam logic [c_CNT_W-1:0] c_ZERO = '0;

    // Storage is deliberately left without reset; emptiness is tracked by
    // r_cnt and the read outputs are masked whenever the queue is empty.
    logic [ADDR_WIDTH-1:0] r_mem_pc   [DEPTH];
    logic [INST_WIDTH-1:0] r_mem_inst [DEPTH];

    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_cnt;

    logic w_if_ready;
    logic w_id_valid;
    logic w_enq;
    logic w_deq;

    // Outputs come from registered state only. A full queue refuses fetch
    // even when decode pops in the same cycle (no full pass-through).
    assign w_if_ready = (r_cnt != c_FULL);
    assign w_id_valid = (r_cnt != c_ZERO);

    // Flush wins over both handshakes: neither pointer moves nor is storage
    // written during a flush cycle.
    assign w_enq = if_valid && w_if_ready && !flush;
    assign w_deq = w_id_valid && id_ready && !flush;

    assign if_ready = w_if_ready;
    assign id_valid = w_id_valid;
    assign count    = r_cnt;
    assign id_pc    = w_id_valid ? r_mem_pc[r_rd_ptr]   : '0;
    assign id_inst  = w_id_valid ? r_mem_inst[r_rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_mem_pc[r_wr_ptr]   <= if_pc;
            r_mem_inst[r_wr_ptr] <= if_inst;
        end
    end

    // Pointers are exactly log2(DEPTH) bits, so the increment wraps from
    // DEPTH-1 to 0 without an explicit compare. Full vs empty is decided by
    // r_cnt, never by pointer equality.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            if (w_enq) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_deq) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_enq, w_deq})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_if_id_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_id_queue
// Purpose  : Directed self-checking bench for if_id_queue (DEPTH = 4).
//            Inputs change on the falling edge; outputs are checked on the
//            falling edge after each rising edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_if_id_queue;

    localparam int ADDR_WIDTH = 32;
    localparam int INST_WIDTH = 32;
    localparam int DEPTH      = 4;

    logic                  clk;
    logic                  rst;
    logic                  flush;
    logic                  if_valid;
    logic [ADDR_WIDTH-1:0] if_pc;
    logic [INST_WIDTH-1:0] if_inst;
    logic                  if_ready;
    logic                  id_valid;
    logic [ADDR_WIDTH-1:0] id_pc;
    logic [INST_WIDTH-1:0] id_inst;
    logic                  id_ready;
    logic [2:0]            count;

    int r_tests;
    int r_fails;

    if_id_queue #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .INST_WIDTH(INST_WIDTH),
        .DEPTH     (DEPTH)
    ) u_dut (
        .clk     (clk),
        .rst     (rst),
        .flush   (flush),
        .if_valid(if_valid),
        .if_pc   (if_pc),
        .if_inst (if_inst),
        .if_ready(if_ready),
        .id_valid(id_valid),
        .id_pc   (id_pc),
        .id_inst (id_inst),
        .id_ready(id_ready),
        .count   (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        r_tests++;
        assert (obs === exp) else begin
            r_fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
        end
    endtask

    // Apply one cycle of stimulus, then land on the following falling edge.
    task automatic step(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                        input logic rdy, input logic fl);
        if_valid = v;
        if_pc    = pc;
        if_inst  = inst;
        id_ready = rdy;
        flush    = fl;
        @(posedge clk);
        @(negedge clk);
        if_valid = 1'b0;
        id_ready = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic chk_head(input string name, input logic [2:0] cnt,
                            input logic [31:0] pc, input logic [31:0] inst);
        chk({name, "_count"}, 64'(count), 64'(cnt));
        chk({name, "_id_valid"}, 64'(id_valid), 64'(cnt != 3'd0));
        chk({name, "_id_pc"}, 64'(id_pc), 64'(pc));
        chk({name, "_id_inst"}, 64'(id_inst), 64'(inst));
    endtask

    initial begin
        r_tests  = 0;
        r_fails  = 0;
        rst      = 1'b1;
        flush    = 1'b0;
        if_valid = 1'b0;
        if_pc    = '0;
        if_inst  = '0;
        id_ready = 1'b0;

        // Reset state while rst is held
        #2;
        chk_head("rst_hold", 3'd0, 32'h0, 32'h0);
        chk("rst_hold_if_ready", 64'(if_ready), 64'd1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk_head("post_rst", 3'd0, 32'h0, 32'h0);

        // Fill to full with decode stalled; head stays at pc 0x00
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 32'(i * 4), 32'h13 + 32'(i), 1'b0, 1'b0);
            chk_head($sformatf("fill%0d", i), 3'(i + 1), 32'h00, 32'h13);
        end
        chk("full_if_ready", 64'(if_ready), 64'd0);

        // 5th push while full is refused
        step(1'b1, 32'h10, 32'h17, 1'b0, 1'b0);
        chk_head("push_full", 3'd4, 32'h00, 32'h13);

        // Push + pop at full: only the pop happens
        step(1'b1, 32'h10, 32'h17, 1'b1, 1'b0);
        chk_head("pushpop_full", 3'd3, 32'h04, 32'h14);
        chk("pushpop_full_if_ready", 64'(if_ready), 64'd1);

        // Pop one more -> cnt 2
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        chk_head("pop_to2", 3'd2, 32'h08, 32'h15);

        // Push + pop at cnt 2: count holds, head advances, 0x10 wraps to slot 0
        step(1'b1, 32'h10, 32'h17, 1'b1, 1'b0);
        chk_head("pushpop_2", 3'd2, 32'h0C, 32'h16);

        // Push 0x14 into slot 1
        step(1'b1, 32'h14, 32'h18, 1'b0, 1'b0);
        chk_head("push14", 3'd3, 32'h0C, 32'h16);

        // Drain in order across the wrap
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        chk_head("drain0", 3'd2, 32'h10, 32'h17);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        chk_head("drain1", 3'd1, 32'h14, 32'h18);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        chk_head("drain2", 3'd0, 32'h0, 32'h0);

        // Empty pops are ignored and outputs stay zero
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
            chk_head($sformatf("empty_pop%0d", i), 3'd0, 32'h0, 32'h0);
        end
        // Pointers must still agree: next push shows up at the head
        step(1'b1, 32'h20, 32'hAA, 1'b0, 1'b0);
        chk_head("after_empty", 3'd1, 32'h20, 32'hAA);

        // Build cnt 3 then flush with both handshakes active
        step(1'b1, 32'h24, 32'hAB, 1'b0, 1'b0);
        step(1'b1, 32'h28, 32'hAC, 1'b0, 1'b0);
        chk_head("pre_flush", 3'd3, 32'h20, 32'hAA);
        step(1'b1, 32'h40, 32'hEE, 1'b1, 1'b1);
        chk_head("flush", 3'd0, 32'h0, 32'h0);
        chk("flush_if_ready", 64'(if_ready), 64'd1);
        step(1'b1, 32'h50, 32'hBB, 1'b0, 1'b0);
        chk_head("post_flush", 3'd1, 32'h50, 32'hBB);

        // Async reset between edges with cnt 3
        step(1'b1, 32'h60, 32'hC0, 1'b0, 1'b0);
        step(1'b1, 32'h64, 32'hC1, 1'b0, 1'b0);
        chk_head("pre_arst", 3'd3, 32'h50, 32'hBB);
        #1;
        rst = 1'b1;
        #1;
        chk_head("arst", 3'd0, 32'h0, 32'h0);
        chk("arst_if_ready", 64'(if_ready), 64'd1);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk_head("arst_release", 3'd0, 32'h0, 32'h0);
        step(1'b1, 32'h70, 32'hD0, 1'b0, 1'b0);
        chk_head("arst_push", 3'd1, 32'h70, 32'hD0);

        $display("[TB] %0d tests run, %0d failed", r_tests, r_fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/if_id_queue.md
Name: if_id_queue

Overview:
Parametrised IF/ID boundary for the RISC-V pipeline. It replaces the single unconditional pc/inst register with a DEPTH-entry instruction queue that uses valid/ready handshakes on both sides. Fetch can run ahead of a stalled decode, and a branch or jump resolution can flush the queue in one cycle. The block sits between the fetch stage and the decode stage.

Parameters:
ADDR_WIDTH, 32, width of the instruction address (pc)
INST_WIDTH, 32, width of the instruction word
DEPTH, 4, number of queue entries; power of two, minimum 2

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  reset; asynchronous, active-high
flush  input  1  synchronous discard of all queued entries
if_valid  input  1  fetch presents a valid pc/inst pair
if_pc  input  ADDR_WIDTH  pc of the fetched instruction
if_inst  input  INST_WIDTH  fetched instruction word
if_ready  output  1  queue can accept an entry this cycle
id_valid  output  1  head entry is valid for decode
id_pc  output  ADDR_WIDTH  pc of the head entry
id_inst  output  INST_WIDTH  instruction word of the head entry
id_ready  input  1  decode consumes the head entry this cycle
count  output  $clog2(DEPTH)+1  number of occupied entries

Behaviour:
- State: storage array mem[DEPTH]{pc,inst}, write pointer wr_ptr, read pointer rd_ptr (each $clog2(DEPTH) bits), occupancy cnt ($clog2(DEPTH)+1 bits).
- Reset (asynchronous, active-high):
  - wr_ptr, rd_ptr and cnt clear to 0 immediately, without waiting for a clock edge.
  - The storage array is not reset.
  - While rst is high: if_ready=1, id_valid=0, id_pc=0, id_inst=0, count=0.
- Output derivation, all from registered state only (no combinational path from inputs to outputs):
  - if_ready = (cnt != DEPTH).
  - id_valid = (cnt != 0).
  - count = cnt.
  - id_pc and id_inst = mem[rd_ptr] when id_valid=1; forced to all-zero when id_valid=0.
- Enqueue: occurs when if_valid && if_ready.
  - mem[wr_ptr] <= {if_pc, if_inst}; wr_ptr increments modulo DEPTH.
- Dequeue: occurs when id_valid && id_ready.
  - rd_ptr increments modulo DEPTH.
- Occupancy update:
  - Enqueue only: cnt+1.
  - Dequeue only: cnt-1.
  - Enqueue and dequeue in the same cycle: cnt unchanged, both pointers advance.
- Latency:
  - An entry enqueued at edge N appears on id_* with id_valid=1 from edge N onward.
  - First-word fall-through with one-edge latency; no bypass from if_* to id_*.
- Full (cnt=DEPTH):
  - if_ready=0, even if decode dequeues in the same cycle; there is no full pass-through.
  - The dequeue proceeds; if_ready rises after that edge.
- Empty (cnt=0):
  - id_valid=0 and id_pc/id_inst are zero.
  - id_ready is ignored; no underflow, pointers unchanged.
- Wrap-around: pointers wrap from DEPTH-1 to 0 naturally. The full/empty distinction comes from cnt, not from pointer equality.
- Flush (synchronous):
  - At the edge: wr_ptr, rd_ptr and cnt clear to 0.
  - Flush has priority over any enqueue or dequeue handshake in the same cycle; both are dropped and storage is not written.
  - The cycle after the flush: id_valid=0 and if_ready=1.
- Reset mid-operation: rst asserted at any time empties the queue asynchronously. Entries enqueued before reset never reappear after reset releases.
- No X propagation: when empty, id_pc and id_inst must be zero even if storage holds X after reset.

Test Plan:
- Reset:
  - Stimulus: assert rst between edges with cnt=3.
  - Required: count=0, id_valid=0, id_pc=0, id_inst=0, if_ready=1 before the next edge.
- Fill to full (DEPTH=4, id_ready=0):
  - Stimulus: push pc 0x00,0x04,0x08,0x0C with inst 0x00000013 + i.
  - Required: count reaches 4, if_ready=0; a 5th push (pc 0x10) is not accepted; id_pc=0x00.
- Drain in order with wrap:
  - Stimulus: from full, dequeue 2 entries, enqueue pc 0x10 and 0x14, then dequeue all.
  - Required: id_pc sequence 0x00,0x04,0x08,0x0C,0x10,0x14; count reaches 0; id_valid=0 after the last dequeue.
- Simultaneous enqueue and dequeue:
  - Stimulus: at cnt=2, push and pop in the same cycle.
  - Required: count stays 2; head advances; the new entry lands at the tail.
  - Stimulus: same at cnt=4.
  - Required: only the pop occurs; count=3.
- Flush with concurrent handshake:
  - Stimulus: cnt=3, assert flush with if_valid=1 (pc 0x40) and id_ready=1.
  - Required: next cycle count=0, id_valid=0; pc 0x40 never appears on id_pc.
- Empty pop and zero outputs:
  - Stimulus: cnt=0, id_ready=1 for 3 cycles.
  - Required: count stays 0, pointers unchanged, id_pc=0, id_inst=0 throughout.
